// File: rtl/sensor_conditioner.sv
// Six-channel sensor front end: 2-flop synchroniser, shared sample-tick prescaler,
// per-channel tick-based debounce, power-up validity flag and registered change pulse.
module sensor_conditioner #(
  parameter int PRESCALE = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_low_water_level,
  input  logic raw_mid_water_level,
  input  logic raw_high_water_level,
  input  logic raw_earth_humidity,
  input  logic raw_air_humidity,
  input  logic raw_low_temperature,
  output logic low_water_level,
  output logic mid_water_level,
  output logic high_water_level,
  output logic earth_humidity,
  output logic air_humidity,
  output logic low_temperature,
  output logic sensors_valid,
  output logic change_pulse
);

  localparam int NCH   = 6;
  localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int AGE_W = $clog2(DEBOUNCE + 1);

  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);
  localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(DEBOUNCE - 1);
  localparam logic [AGE_W-1:0] AGE_FULL = AGE_W'(DEBOUNCE);

  logic [NCH-1:0]   raw_vec;
  logic [NCH-1:0]   sync1_q, sync1_d;
  logic [NCH-1:0]   sync2_q, sync2_d;
  logic [PS_W-1:0]  ps_q, ps_d;
  logic             tick;
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];
  logic [NCH-1:0]   filt_q, filt_d;
  logic [NCH-1:0]   filt_prev_q, filt_prev_d;
  logic             pulse_q, pulse_d;
  logic [AGE_W-1:0] age_q, age_d;
  logic             valid_q, valid_d;

  assign raw_vec = {raw_low_temperature, raw_air_humidity, raw_earth_humidity,
                    raw_high_water_level, raw_mid_water_level, raw_low_water_level};

  always_comb begin
    sync1_d     = raw_vec;
    sync2_d     = sync1_q;
    tick        = (ps_q == PS_LAST);
    ps_d        = tick ? '0 : ps_q + 1'b1;
    filt_d      = filt_q;
    cnt_d       = cnt_q;
    age_d       = age_q;
    valid_d     = valid_q;
    // Change detection compares against last cycle's outputs so the pulse lands one cycle after a flip.
    filt_prev_d = filt_q;
    pulse_d     = |(filt_q ^ filt_prev_q);

    if (tick) begin
      for (int i = 0; i < NCH; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          filt_d[i] = ~filt_q[i];
          cnt_d[i]  = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
      if (age_q < AGE_FULL) begin
        age_d = age_q + 1'b1;
      end
      if (age_q == AGE_LAST) begin
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      ps_q        <= '0;
      cnt_q       <= '{default: '0};
      filt_q      <= '0;
      filt_prev_q <= '0;
      pulse_q     <= 1'b0;
      age_q       <= '0;
      valid_q     <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      ps_q        <= ps_d;
      cnt_q       <= cnt_d;
      filt_q      <= filt_d;
      filt_prev_q <= filt_prev_d;
      pulse_q     <= pulse_d;
      age_q       <= age_d;
      valid_q     <= valid_d;
    end
  end

  assign low_water_level  = filt_q[0];
  assign mid_water_level  = filt_q[1];
  assign high_water_level = filt_q[2];
  assign earth_humidity   = filt_q[3];
  assign air_humidity     = filt_q[4];
  assign low_temperature  = filt_q[5];
  assign sensors_valid    = valid_q;
  assign change_pulse     = pulse_q;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed bench for sensor_conditioner: slow instance (PRESCALE=4, DEBOUNCE=3)
// and pass-through instance (PRESCALE=1, DEBOUNCE=1).
module tb_sensor_conditioner;

  logic       clk = 1'b0;
  logic       rst_n, rst_f;
  logic [5:0] raw, raw_f;
  logic [5:0] filt, filt_f;
  logic       valid, pulse, valid_f, pulse_f;

  int checks, passes, fails;
  int cyc, pulse_cnt, base;

  always #5 clk = ~clk;

  sensor_conditioner #(.PRESCALE(4), .DEBOUNCE(3)) u_dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .raw_low_water_level  (raw[0]),
    .raw_mid_water_level  (raw[1]),
    .raw_high_water_level (raw[2]),
    .raw_earth_humidity   (raw[3]),
    .raw_air_humidity     (raw[4]),
    .raw_low_temperature  (raw[5]),
    .low_water_level      (filt[0]),
    .mid_water_level      (filt[1]),
    .high_water_level     (filt[2]),
    .earth_humidity       (filt[3]),
    .air_humidity         (filt[4]),
    .low_temperature      (filt[5]),
    .sensors_valid        (valid),
    .change_pulse         (pulse)
  );

  sensor_conditioner #(.PRESCALE(1), .DEBOUNCE(1)) u_dut_fast (
    .clk                  (clk),
    .rst_n                (rst_f),
    .raw_low_water_level  (raw_f[0]),
    .raw_mid_water_level  (raw_f[1]),
    .raw_high_water_level (raw_f[2]),
    .raw_earth_humidity   (raw_f[3]),
    .raw_air_humidity     (raw_f[4]),
    .raw_low_temperature  (raw_f[5]),
    .low_water_level      (filt_f[0]),
    .mid_water_level      (filt_f[1]),
    .high_water_level     (filt_f[2]),
    .earth_humidity       (filt_f[3]),
    .air_humidity         (filt_f[4]),
    .low_temperature      (filt_f[5]),
    .sensors_valid        (valid_f),
    .change_pulse         (pulse_f)
  );

  task automatic applyStimulus(input logic [5:0] value);
    raw = value;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Edges are counted from reset release; inputs change and outputs are sampled 1 time unit after each edge.
  task automatic advTo(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
      cyc++;
      if (pulse === 1'b1) pulse_cnt++;
    end
  endtask

  initial begin
    checks = 0; passes = 0; fails = 0; cyc = 0; pulse_cnt = 0; base = 0;
    rst_n = 1'b0;
    rst_f = 1'b0;
    raw   = 6'b111111;
    raw_f = 6'b000000;

    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("reset_filt", {2'b00, filt}, 8'h00);
      checkOutput("reset_valid_pulse", {6'b0, valid, pulse}, 8'h00);
    end

    applyStimulus(6'b001000);
    rst_n = 1'b1;
    cyc   = 0;
    advTo(11);
    checkOutput("settle_before_filt", {2'b00, filt}, 8'h00);
    checkOutput("settle_before_valid", {7'b0, valid}, 8'h00);
    advTo(12);
    checkOutput("settle_filt", {2'b00, filt}, 8'h08);
    checkOutput("settle_valid", {7'b0, valid}, 8'h01);
    checkOutput("settle_pulse_c12", {7'b0, pulse}, 8'h00);
    advTo(13);
    checkOutput("settle_pulse_c13", {7'b0, pulse}, 8'h01);
    advTo(14);
    checkOutput("settle_pulse_c14", {7'b0, pulse}, 8'h00);
    checkOutput("settle_pulse_count", 8'(pulse_cnt), 8'd1);

    base = pulse_cnt;
    applyStimulus(6'b001010);
    advTo(22);
    applyStimulus(6'b001000);
    advTo(40);
    checkOutput("glitch_filt", {2'b00, filt}, 8'h08);
    checkOutput("glitch_no_pulse", 8'(pulse_cnt - base), 8'd0);

    applyStimulus(6'b001010);
    advTo(51);
    checkOutput("hold_before_flip", {2'b00, filt}, 8'h08);
    advTo(52);
    checkOutput("hold_flip", {2'b00, filt}, 8'h0A);
    advTo(53);
    checkOutput("hold_pulse", {7'b0, pulse}, 8'h01);

    applyStimulus(6'b001000);
    advTo(60);
    applyStimulus(6'b001010);
    advTo(64);
    applyStimulus(6'b001000);
    advTo(68);
    checkOutput("restart_tick4", {2'b00, filt}, 8'h0A);
    advTo(75);
    checkOutput("restart_before_flip", {2'b00, filt}, 8'h0A);
    advTo(76);
    checkOutput("restart_flip", {2'b00, filt}, 8'h08);
    advTo(77);
    checkOutput("restart_pulse", {7'b0, pulse}, 8'h01);

    base = pulse_cnt;
    applyStimulus(6'b001101);
    advTo(87);
    checkOutput("simul_before_flip", {2'b00, filt}, 8'h08);
    advTo(88);
    checkOutput("simul_flip", {2'b00, filt}, 8'h0D);
    advTo(89);
    checkOutput("simul_pulse", {7'b0, pulse}, 8'h01);
    advTo(95);
    checkOutput("simul_single_pulse", 8'(pulse_cnt - base), 8'd1);

    applyStimulus(6'b011101);
    advTo(106);
    rst_n = 1'b0;
    advTo(107);
    checkOutput("midreset_filt", {2'b00, filt}, 8'h00);
    checkOutput("midreset_valid_pulse", {6'b0, valid, pulse}, 8'h00);
    rst_n = 1'b1;
    cyc   = 0;
    base  = pulse_cnt;
    advTo(11);
    checkOutput("midreset_refilter_before", {2'b00, filt}, 8'h00);
    checkOutput("midreset_valid_before", {7'b0, valid}, 8'h00);
    advTo(12);
    checkOutput("midreset_refilter_flip", {2'b00, filt}, 8'h1D);
    checkOutput("midreset_valid_after", {7'b0, valid}, 8'h01);
    advTo(14);
    checkOutput("midreset_single_pulse", 8'(pulse_cnt - base), 8'd1);

    raw_f = 6'b001000;
    rst_f = 1'b1;
    cyc   = 0;
    advTo(1);
    checkOutput("fast_valid", {7'b0, valid_f}, 8'h01);
    advTo(2);
    checkOutput("fast_latency_c2", {2'b00, filt_f}, 8'h00);
    advTo(3);
    checkOutput("fast_latency_c3", {2'b00, filt_f}, 8'h08);
    advTo(4);
    checkOutput("fast_pulse_c4", {7'b0, pulse_f}, 8'h01);
    advTo(5);
    checkOutput("fast_pulse_c5", {7'b0, pulse_f}, 8'h00);
    raw_f = 6'b000000;
    advTo(7);
    checkOutput("fast_fall_before", {2'b00, filt_f}, 8'h08);
    advTo(8);
    checkOutput("fast_fall", {2'b00, filt_f}, 8'h00);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sensor_conditioner.md
Name: sensor_conditioner

Overview:
Upstream front end of the irrigation controller. It takes the six raw field sensor lines and synchronises each one to the clock, then debounces it over a slow sample tick. It presents stable, glitch-free levels to the irrigation controller's sensor inputs. It also flags when the filtered set is trustworthy and pulses on any filtered change.

Parameters:
PRESCALE, 1000, clock cycles per sample tick; legal range 1 and up.
DEBOUNCE, 4, consecutive differing tick samples needed to flip a filtered output; legal range 1 and up.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
raw_low_water_level  input  1  asynchronous level sensor, low mark
raw_mid_water_level  input  1  asynchronous level sensor, mid mark
raw_high_water_level  input  1  asynchronous level sensor, high mark
raw_earth_humidity  input  1  asynchronous soil humidity switch
raw_air_humidity  input  1  asynchronous air humidity switch
raw_low_temperature  input  1  asynchronous low-temperature switch
low_water_level  output  1  filtered low mark
mid_water_level  output  1  filtered mid mark
high_water_level  output  1  filtered high mark
earth_humidity  output  1  filtered soil humidity
air_humidity  output  1  filtered air humidity
low_temperature  output  1  filtered low temperature
sensors_valid  output  1  high once all channels have had DEBOUNCE ticks since reset
change_pulse  output  1  one-cycle pulse when any filtered output toggles

Behaviour:
- Reset is synchronous and active-low: rst_n is sampled on the clk rising edge.
- While rst_n=0, every register clears: synchroniser flops, prescaler, per-channel counters, the tick-age counter, all six filtered outputs, sensors_valid and change_pulse.
- Reset applied mid-operation (mid-count or mid-debounce) has the same effect. No partial state survives.
- Synchroniser: each raw input passes through 2 flops, so sync_x lags raw_x by 2 clocks.
- Prescaler: counts 0..PRESCALE-1 and wraps to 0. tick=1 in the cycle where the count equals PRESCALE-1.
- With PRESCALE=1, tick is high every cycle.
- The first tick occurs PRESCALE cycles after the first edge with rst_n=1.
- Per-channel debounce, evaluated only when tick=1; between ticks, counters and outputs hold:
  - If sync_x equals filt_x: cnt_x clears to 0.
  - If sync_x differs from filt_x and cnt_x is below DEBOUNCE-1: cnt_x increments.
  - If sync_x differs from filt_x and cnt_x equals DEBOUNCE-1: filt_x inverts at that edge and cnt_x clears to 0.
  - With DEBOUNCE=1, the output flips on the first differing tick sample.
- Counter width is clog2(DEBOUNCE), minimum 1 bit. Counters never exceed DEBOUNCE-1 and never wrap.
- A glitch shorter than DEBOUNCE consecutive ticks never reaches the outputs. One agreeing sample restarts the count.
- All channels are independent and may flip on the same tick.
- No cross-channel consistency check is made. Level-inconsistency detection belongs to the downstream controller.
- change_pulse:
  - Registered. It goes high for exactly 1 cycle, in the cycle after any filtered output changed.
  - Simultaneous flips on several channels produce a single pulse.
  - Since flips only happen on ticks, pulses are at least PRESCALE cycles apart.
- sensors_valid:
  - A saturating tick-age counter increments on each tick.
  - sensors_valid goes to 1 at the edge of the DEBOUNCE-th tick after reset, the same edge where a reset-0 output facing a steady 1 input first flips.
  - It then stays 1 until reset.
- Filtered outputs connect one-to-one to the irrigation controller's sensor inputs of the same names.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with all raw inputs at 1 -> all outputs, sensors_valid and change_pulse read 0 throughout.
- Power-up settle (PRESCALE=4, DEBOUNCE=3): raw_earth_humidity=1 held from reset release -> earth_humidity and sensors_valid rise together at the 3rd tick (cycle 12). change_pulse is high in cycle 13 only. All other outputs stay 0.
- Glitch rejection (PRESCALE=4, DEBOUNCE=3): after settle, pulse raw_mid_water_level to 1 for 2 ticks, then 0 -> mid_water_level stays 0 and no change_pulse. Hold it at 1 for 3 ticks -> the output flips at the 3rd tick.
- Count restart (PRESCALE=4, DEBOUNCE=3): raw pattern differ, differ, agree, differ, differ, differ on successive ticks -> the flip occurs only at the 6th tick.
- Simultaneous flips: raw_low_water_level and raw_high_water_level toggle in the same cycle -> both outputs flip on the same tick, with a single 1-cycle change_pulse.
- Reset mid-debounce: assert rst_n=0 one cycle before the flipping tick -> outputs remain 0, and a full DEBOUNCE ticks are needed again after release. Also repeat the power-up settle case with PRESCALE=1, DEBOUNCE=1 -> the output follows the raw input 3 cycles later (2 synchroniser flops plus the filter register).
